// File: rtl/alu_mul_sequencer_pkg.sv
// Shared definitions for the multiply sequencer: ALU function codes and FSM states.
package alu_mul_sequencer_pkg;

  localparam logic [2:0] ALU_F3_ADD = 3'b000;
  localparam logic [6:0] ALU_F7_ADD = 7'b0000000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mul_sequencer_inc_cnt.sv
// Ripple incrementer (value + 1) built only from XOR/AND gates.
module alu_mul_sequencer_inc_cnt #(
  parameter int W = 6
) (
  input  logic [W-1:0] iVal,
  output logic [W-1:0] oVal
);

  logic [W-1:0] carry;

  // carry[i] is set when every bit below i is one; the +1 enters at bit 0.
  always_comb begin
    carry = '0;
    carry[0] = 1'b1;
    for (int i = 1; i < W; i++) begin
      carry[i] = carry[i-1] & iVal[i-1];
    end
  end

  assign oVal = iVal ^ carry;

endmodule

// File: rtl/alu_mul_sequencer.sv
// Shift-add MUL sequencer that borrows the shared ALU's ADD path for every partial sum.
module alu_mul_sequencer
  import alu_mul_sequencer_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int CNT_W      = 6,
  parameter int EARLY_EXIT = 1
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iValid,
  output logic             oReady,
  input  logic [WIDTH-1:0] iDataA,
  input  logic [WIDTH-1:0] iDataB,
  output logic             oValid,
  input  logic             iReady,
  output logic [WIDTH-1:0] oData,
  output logic             oZero,
  output logic             oAluOwn,
  output logic [WIDTH-1:0] oAluA,
  output logic [WIDTH-1:0] oAluB,
  output logic [2:0]       oAluFunct3,
  output logic [6:0]       oAluFunct7,
  input  logic [WIDTH-1:0] iAluResult,
  output state_t           oDbgState
);

  // Handshakes: a request transfers on the rising edge where iValid & oReady;
  // a result transfers on the rising edge where oValid & iReady. Both sides
  // must hold valid (and its data) until the transfer happens.

  state_t             state;
  state_t             stateNext;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cntInc;
  logic [WIDTH-1:0]   accNext;
  logic               lastIter;

  alu_mul_sequencer_inc_cnt #(.W(CNT_W)) uIncCnt (
    .iVal (cnt),
    .oVal (cntInc)
  );

  // The ALU result is only consumed when the current multiplier bit is set.
  assign accNext  = mplier[0] ? iAluResult : acc;
  assign lastIter = (cnt == CNT_W'(WIDTH - 1)) ||
                    ((EARLY_EXIT != 0) && (mplier[WIDTH-1:1] == '0));

  always_comb begin
    stateNext = state;
    case (state)
      S_IDLE:  if (iValid)   stateNext = S_RUN;
      S_RUN:   if (lastIter) stateNext = S_DONE;
      S_DONE:  if (iReady)   stateNext = S_IDLE;
      default: stateNext = S_IDLE;
    endcase
  end

  assign oReady     = (state == S_IDLE);
  assign oValid     = (state == S_DONE);
  assign oAluOwn    = (state == S_RUN);
  assign oAluA      = oAluOwn ? acc   : '0;
  assign oAluB      = oAluOwn ? mcand : '0;
  assign oAluFunct3 = ALU_F3_ADD;
  assign oAluFunct7 = ALU_F7_ADD;
  assign oDbgState  = state;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state  <= S_IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      oData  <= '0;
      oZero  <= 1'b1;
    end else begin
      state <= stateNext;
      case (state)
        S_IDLE: begin
          if (iValid) begin
            acc    <= '0;
            mcand  <= iDataA;
            mplier <= iDataB;
            cnt    <= '0;
          end
        end
        S_RUN: begin
          acc    <= accNext;
          mcand  <= {mcand[WIDTH-2:0], 1'b0};
          mplier <= {1'b0, mplier[WIDTH-1:1]};
          cnt    <= cntInc;
          if (lastIter) begin
            oData <= accNext;
            oZero <= ~|accNext;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer: two instances (EARLY_EXIT 0 and 1), each with its own ALU model.
module tb_alu_mul_sequencer;
  import alu_mul_sequencer_pkg::*;

  localparam int WIDTH = 32;

  logic                   clk;
  logic                   rst;
  logic [1:0]             valid, rdyIn, outReady, outValid, zero, own;
  logic [1:0][WIDTH-1:0]  dA, dB, outData, aluA, aluB, aluRes;
  logic [1:0][2:0]        f3;
  logic [1:0][6:0]        f7;
  logic [1:0][1:0]        dbg;

  int nChecks = 0;
  int nFail   = 0;
  logic [WIDTH-1:0] expQ[$];

  typedef struct {
    int               sel;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] expData;
    logic             expZero;
    int               expN;
    int               hold;
  } vec_t;

  vec_t vecs[10];

  // Register-register ALU: ADD/SUB, XOR, OR, AND.
  function automatic logic [WIDTH-1:0] aluModel(input logic [WIDTH-1:0] a, b,
                                                input logic [2:0] fn3, input logic [6:0] fn7);
    case (fn3)
      3'b000:  aluModel = fn7[5] ? a - b : a + b;
      3'b100:  aluModel = a ^ b;
      3'b110:  aluModel = a | b;
      3'b111:  aluModel = a & b;
      default: aluModel = '0;
    endcase
  endfunction

  // Iterations expected: full width, or bit length of B (at least one).
  function automatic int refIters(input int ee, input logic [WIDTH-1:0] b);
    int n;
    if (ee == 0) return WIDTH;
    n = 1;
    for (int i = 0; i < WIDTH; i++) if (b[i]) n = i + 1;
    return n;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gDut
    assign aluRes[g] = aluModel(aluA[g], aluB[g], f3[g], f7[g]);
    alu_mul_sequencer #(.WIDTH(WIDTH), .CNT_W(6), .EARLY_EXIT(g)) uDut (
      .iClk       (clk),
      .iRst       (rst),
      .iValid     (valid[g]),
      .oReady     (outReady[g]),
      .iDataA     (dA[g]),
      .iDataB     (dB[g]),
      .oValid     (outValid[g]),
      .iReady     (rdyIn[g]),
      .oData      (outData[g]),
      .oZero      (zero[g]),
      .oAluOwn    (own[g]),
      .oAluA      (aluA[g]),
      .oAluB      (aluB[g]),
      .oAluFunct3 (f3[g]),
      .oAluFunct7 (f7[g]),
      .iAluResult (aluRes[g]),
      .oDbgState  (dbg[g])
    );
  end

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Continuous interface rules, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("funct3_%0d", k), 64'(f3[k]), 64'(3'b000));
        check($sformatf("funct7_%0d", k), 64'(f7[k]), 64'(7'b0000000));
        if (own[k]) begin
          check($sformatf("own_excl_%0d", k), 64'({outValid[k], outReady[k]}), 64'(0));
        end else begin
          check($sformatf("idle_ops_%0d", k), 64'({aluA[k], aluB[k]}), 64'(0));
        end
      end
    end
  end

  // Driver: wait for ready, issue one request, wait for the result, hold, consume.
  task automatic runOp(input int k, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] expD, input logic expZ, input int expN,
                       input int hold, input string name);
    int lat;
    int ownCnt;
    bit seen;
    logic [WIDTH-1:0] expPop;
    lat = 0;
    while (!outReady[k] && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_ready"}, 64'(outReady[k]), 64'(1));
    expQ.push_back(expD);
    valid[k] = 1'b1;
    dA[k] = a;
    dB[k] = b;
    @(posedge clk);
    #1;
    valid[k] = 1'b0;
    dA[k] = $urandom;
    dB[k] = $urandom;
    lat = 0;
    ownCnt = 0;
    seen = 1'b0;
    while (!seen && lat < 200) begin
      @(negedge clk);
      lat++;
      if (outValid[k]) seen = 1'b1;
      else if (own[k]) ownCnt++;
    end
    expPop = expQ.pop_front();
    check({name, "_valid"}, 64'(seen), 64'(1));
    check({name, "_latency"}, 64'(lat - 1), 64'(expN));
    check({name, "_owncycles"}, 64'(ownCnt), 64'(expN));
    check({name, "_data"}, 64'(outData[k]), 64'(expPop));
    check({name, "_zero"}, 64'(zero[k]), 64'(expZ));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({name, "_hold"}, 64'({outValid[k], outReady[k], outData[k]}),
            64'({1'b1, 1'b0, expPop}));
    end
    rdyIn[k] = 1'b1;
    @(posedge clk);
    #1;
    rdyIn[k] = 1'b0;
    @(negedge clk);
    check({name, "_release"}, 64'({outReady[k], outValid[k]}), 64'({1'b1, 1'b0}));
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    valid = '0;
    rdyIn = '0;
    dA = '0;
    dB = '0;
    rst = 1'b1;

    vecs[0] = '{1, 32'd3,          32'd5,          32'd15,         1'b0, 3,  0};
    vecs[1] = '{0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  1'b0, 32, 0};
    vecs[2] = '{1, 32'h8000_0000,  32'd2,          32'd0,          1'b1, 2,  0};
    vecs[3] = '{1, 32'h0000_1234,  32'd0,          32'd0,          1'b1, 1,  0};
    vecs[4] = '{1, 32'd7,          32'd6,          32'd42,         1'b0, 3,  10};
    vecs[5] = '{1, 32'd11,         32'd13,         32'd143,        1'b0, 4,  0};
    vecs[6] = '{0, 32'd7,          32'd6,          32'd42,         1'b0, 32, 3};
    vecs[7] = '{1, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  1'b0, 1,  0};
    vecs[8] = '{1, 32'h0001_0000,  32'h0001_0000,  32'd0,          1'b1, 17, 0};
    vecs[9] = '{1, 32'hFFFF_FFFE,  32'h8000_0003,  32'hFFFF_FFFA,  1'b0, 32, 0};

    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_ready_%0d", k), 64'(outReady[k]), 64'(1));
      check($sformatf("rst_valid_%0d", k), 64'(outValid[k]), 64'(0));
      check($sformatf("rst_own_%0d", k), 64'(own[k]), 64'(0));
      check($sformatf("rst_data_%0d", k), 64'(outData[k]), 64'(0));
      check($sformatf("rst_zero_%0d", k), 64'(zero[k]), 64'(1));
    end
    rst = 1'b0;
    @(negedge clk);

    // Directed table; vec 4 holds the result then is followed back-to-back by vec 5.
    for (int i = 0; i < 10; i++) begin
      runOp(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].expData, vecs[i].expZero,
            vecs[i].expN, vecs[i].hold, $sformatf("vec%0d", i));
    end

    // Asynchronous reset in the middle of a long multiply.
    valid[1] = 1'b1;
    dA[1] = 32'h0000_FFFF;
    dB[1] = 32'h0000_FFFF;
    @(posedge clk);
    #1;
    valid[1] = 1'b0;
    repeat (4) @(negedge clk);
    check("midrun_own", 64'(own[1]), 64'(1));
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_own", 64'(own[1]), 64'(0));
    check("async_rst_valid", 64'(outValid[1]), 64'(0));
    check("async_rst_ready", 64'(outReady[1]), 64'(1));
    check("async_rst_out", 64'({outData[1], zero[1]}), 64'({32'd0, 1'b1}));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    runOp(1, 32'd9, 32'd9, 32'd81, 1'b0, 4, 0, "after_rst");

    // Random sweep against the arithmetic model, alternating instances.
    for (int i = 0; i < 1000; i++) begin
      int k;
      k = i % 2;
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = $urandom_range(0, 255);
        1:       rb = $urandom >> $urandom_range(0, 31);
        2:       rb = 32'h8000_0000 >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      runOp(k, ra, rb, ra * rb, (ra * rb) == 0, refIters(k, rb),
            $urandom_range(0, 2), $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2_000_000;
    nChecks++;
    nFail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
